// File: rtl/cnn_mac_pkg.sv
// Shared widths, the multiplier stage record and the output clamp for cnn_mac_pipe.
// mac_stage_t and sat_fn are sized from the defaults here, so top-level overrides must keep them consistent.
package cnn_mac_pkg;
  localparam int A_W_DEF       = 14;
  localparam int B_W_DEF       = 6;
  localparam int ACC_W_DEF     = 32;
  localparam int OUT_W_DEF     = 20;
  localparam int NUM_STAGE_DEF = 2;
  localparam int PROD_W        = A_W_DEF + B_W_DEF + 1;

  typedef struct packed {
    logic                     valid;
    logic                     last;
    logic signed [PROD_W-1:0] prod;
  } mac_stage_t;

  // Returns {ovf, data}: the window sum clamped to the signed OUT_W range.
  function automatic logic [OUT_W_DEF:0] sat_fn(input logic signed [ACC_W_DEF-1:0] acc);
    logic signed [ACC_W_DEF-1:0] hi, lo;
    hi = '0;
    hi[OUT_W_DEF-2:0] = '1;
    lo = ~hi;
    if (acc > hi) return {1'b1, hi[OUT_W_DEF-1:0]};
    if (acc < lo) return {1'b1, lo[OUT_W_DEF-1:0]};
    return {1'b0, acc[OUT_W_DEF-1:0]};
  endfunction
endpackage

// File: rtl/cnn_mac_mul_stage.sv
// Registered signed x unsigned multiplier, NUM_STAGE deep, frozen while hold_i is high.
module cnn_mac_mul_stage
  import cnn_mac_pkg::*;
#(
  parameter int A_W       = A_W_DEF,
  parameter int B_W       = B_W_DEF,
  parameter int NUM_STAGE = NUM_STAGE_DEF
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           hold_i,
  input  logic           vld_i,
  input  logic           last_i,
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output mac_stage_t     stage_o
);
  localparam int P_W = A_W + B_W + 1;

  logic signed [P_W-1:0]                 prod_d;
  logic [NUM_STAGE:1]                    vld_pipe, last_pipe;
  logic [NUM_STAGE:1][P_W-1:0]           prod_pipe;

  // Zero-extending B keeps the weight unsigned inside a fully signed multiply.
  assign prod_d = $signed(a_i) * $signed({1'b0, b_i});

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (!hold_i) begin
      for (int s = NUM_STAGE; s > 1; s--) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        last_pipe[s] <= last_pipe[s-1];
      end
      vld_pipe[1]  <= vld_i;
      last_pipe[1] <= last_i;
    end
  end

  // Data path left unreset so it can be absorbed into the DSP pipeline registers.
  always_ff @(posedge ap_clk) begin
    if (!hold_i) begin
      for (int s = NUM_STAGE; s > 1; s--) prod_pipe[s] <= prod_pipe[s-1];
      prod_pipe[1] <= prod_d;
    end
  end

  always_comb begin
    stage_o       = '0;
    stage_o.valid = vld_pipe[NUM_STAGE];
    stage_o.last  = last_pipe[NUM_STAGE];
    stage_o.prod  = $signed(prod_pipe[NUM_STAGE]);
  end
endmodule

// File: rtl/cnn_mac_pipe.sv
// Windowed MAC: multiplier pipeline, accumulator and a single output register with valid/ready.
// Define CNN_MAC_SAT_EN to clamp out_data to the OUT_W range and report it on out_ovf.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_W       = A_W_DEF,
  parameter int B_W       = B_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int NUM_STAGE = NUM_STAGE_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);
  mac_stage_t          st;
  logic                stall, accept;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                first_q;
  logic                out_valid_q, out_ovf_q;
  logic [OUT_W-1:0]    out_data_q;
  logic [OUT_W:0]      res_d;

  // A held result freezes the whole pipe, so in_ready never depends on in_valid.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;

  cnn_mac_mul_stage #(.A_W(A_W), .B_W(B_W), .NUM_STAGE(NUM_STAGE)) u_mul (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .hold_i   (stall),
    .vld_i    (accept),
    .last_i   (in_last),
    .a_i      (in_a),
    .b_i      (in_b),
    .stage_o  (st)
  );

  always_comb begin
    acc_d = (first_q ? '0 : acc_q) + {{(ACC_W-PROD_W){st.prod[PROD_W-1]}}, st.prod};
`ifdef CNN_MAC_SAT_EN
    res_d = sat_fn(acc_d);
`else
    res_d = {1'b0, acc_d[OUT_W-1:0]};
`endif
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (!stall) begin
      if (st.valid) begin
        acc_q   <= acc_d;
        first_q <= st.last;
      end
      // A completing window reloads the output even while the old one is taken: no bubble.
      if (st.valid && st.last) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res_d[OUT_W-1:0];
        out_ovf_q   <= res_d[OUT_W];
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Bench for cnn_mac_pipe: directed scenarios plus randomized windows against a window-sum model.
module tb_cnn_mac_pipe;
  localparam int NS    = 2;
  localparam int OUT_W = 20;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid, in_ready, in_last;
  logic [13:0] in_a;
  logic [5:0]  in_b;
  logic        out_valid, out_ready, out_ovf;
  logic [19:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  int     act_d[$];
  bit     act_o[$];
  int     exp_d[$];
  bit     exp_o[$];
  longint msum = 0;

  cnn_mac_pipe #(.NUM_STAGE(NS)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 ap_clk = ~ap_clk;

  // Expected result of a whole window: wrap to 32 bits, then clamp or truncate to OUT_W.
  function automatic void model_result(input longint s, output int d, output bit o);
    int          w;
    logic [19:0] t;
    w = int'(s);
`ifdef CNN_MAC_SAT_EN
    if (w > (1 << (OUT_W-1)) - 1)   begin d = (1 << (OUT_W-1)) - 1; o = 1'b1; end
    else if (w < -(1 << (OUT_W-1))) begin d = -(1 << (OUT_W-1));    o = 1'b1; end
    else                            begin d = w;                    o = 1'b0; end
`else
    t = w[19:0];
    d = int'($signed(t));
    o = 1'b0;
`endif
  endfunction

  // Handshakes are observed at the falling edge; both take effect at the next rising edge.
  always @(negedge ap_clk) begin
    int d;
    bit o;
    if (!ap_rst_n) begin
      msum = 0;
    end else begin
      if (out_valid && out_ready) begin
        act_d.push_back(int'($signed(out_data)));
        act_o.push_back(out_ovf);
      end
      if (in_valid && in_ready) begin
        msum += longint'($signed(in_a)) * longint'(in_b);
        if (in_last) begin
          model_result(msum, d, o);
          exp_d.push_back(d);
          exp_o.push_back(o);
          msum = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    act_d.delete(); act_o.delete(); exp_d.delete(); exp_o.delete();
  endtask

  task automatic send(input int a, input int b, input bit last);
    int t = 0;
    bit ok = 1'b0;
    in_valid = 1'b1; in_a = 14'(a); in_b = 6'(b); in_last = last;
    while (!ok && t < 100) begin
      @(negedge ap_clk); ok = in_ready;
      @(posedge ap_clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send: beat (%0d,%0d) not accepted within %0d cycles", a, b, t);
    end
  endtask

  task automatic wait_results(input int n);
    int t = 0;
    while (act_d.size() < n && t < 300) begin @(posedge ap_clk); #1; t++; end
    n_cmp++;
    if (act_d.size() < n) begin
      n_err++;
      $display("FAIL wait_results: got %0d results, need %0d", act_d.size(), n);
    end
  endtask

  task automatic drain();
    repeat (NS + 4) begin @(posedge ap_clk); #1; end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 20'd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", out_data); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_window();
    int lat = 0;
    bit seen = 1'b0;
    clear_q();
    send(3, 2, 0); send(-5, 7, 0); send(100, 63, 1);
    while (!seen && lat < 20) begin @(negedge ap_clk); lat++; seen = out_valid; end
    @(posedge ap_clk); #1;
    n_cmp++; if (lat != NS + 1) begin n_err++; $display("FAIL window_latency: got %0d want %0d", lat, NS + 1); end
    wait_results(1);
    if (act_d.size() >= 1) begin
      n_cmp++; if (act_d[0] != 6271) begin n_err++; $display("FAIL window_data: got %0d want 6271", act_d[0]); end
      n_cmp++; if (act_o[0] != 1'b0) begin n_err++; $display("FAIL window_ovf: got %b want 0", act_o[0]); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    clear_q();
    fork
      begin
        for (int i = 0; i < 8; i++) send(-8192, 63, 1);
      end
      begin
        int t = 0;
        while (!out_valid && t < 20) begin @(negedge ap_clk); t++; end
        for (int k = 0; k < 8; k++) begin
          n_cmp++;
          if (out_valid !== 1'b1 || $signed(out_data) != -516096) begin
            n_err++;
            $display("FAIL b2b_stream[%0d]: got valid=%b data=%0d want valid=1 data=-516096", k, out_valid, $signed(out_data));
          end
          @(negedge ap_clk);
        end
      end
    join
    wait_results(8);
    for (int i = 0; i < act_d.size(); i++) begin
      n_cmp++;
      if (act_d[i] != -516096) begin n_err++; $display("FAIL b2b_result[%0d]: got %0d want -516096", i, act_d[i]); end
    end
    drain();
  endtask

  task automatic test_saturate();
`ifdef CNN_MAC_SAT_EN
    int  want_d = -524288;
    bit  want_o = 1'b1;
`else
    int  want_d = 16384;
    bit  want_o = 1'b0;
`endif
    clear_q();
    send(-8192, 63, 0); send(-8192, 63, 1);
    wait_results(1);
    if (act_d.size() >= 1) begin
      n_cmp++; if (act_d[0] != want_d) begin n_err++; $display("FAIL sat_data: got %0d want %0d", act_d[0], want_d); end
      n_cmp++; if (act_o[0] != want_o) begin n_err++; $display("FAIL sat_ovf: got %b want %b", act_o[0], want_o); end
    end
    drain();
  endtask

  task automatic test_stall();
    int t = 0;
    clear_q();
    out_ready = 1'b0;
    send(5, 5, 1);
    while (!out_valid && t < 20) begin @(negedge ap_clk); t++; end
    @(posedge ap_clk); #1;
    in_valid = 1'b1; in_a = 14'd7; in_b = 6'd3; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 20'd25) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got ready=%b valid=%b data=%0d want ready=0 valid=1 data=25", k, in_ready, out_valid, out_data);
      end
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release: got ready=%b want 1", in_ready); end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    wait_results(2);
    if (act_d.size() >= 2) begin
      n_cmp++; if (act_d[0] != 25) begin n_err++; $display("FAIL stall_first: got %0d want 25", act_d[0]); end
      n_cmp++; if (act_d[1] != 21) begin n_err++; $display("FAIL stall_second: got %0d want 21", act_d[1]); end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    clear_q();
    send(4, 4, 0); send(9, 9, 0);
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    clear_q();
    send(1, 1, 0); send(2, 1, 1);
    wait_results(1);
    if (act_d.size() >= 1) begin
      n_cmp++; if (act_d[0] != 3) begin n_err++; $display("FAIL midrst_result: got %0d want 3", act_d[0]); end
    end
    drain();
  endtask

  task automatic test_gappy_valid();
    clear_q();
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_a = 14'($urandom); in_b = 6'($urandom); in_last = 1'($urandom);
        @(posedge ap_clk); #1;
      end
      send(1, 1, i == 9);
    end
    wait_results(1);
    if (act_d.size() >= 1) begin
      n_cmp++; if (act_d[0] != 10) begin n_err++; $display("FAIL gappy_result: got %0d want 10", act_d[0]); end
    end
    drain();
  endtask

  task automatic test_random();
    bit done = 1'b0;
    clear_q();
    fork
      begin
        for (int w = 0; w < 20; w++) begin
          int len = $urandom_range(1, 5);
          for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(posedge ap_clk); #1; end
            send($urandom_range(0, 16383), $urandom_range(0, 63), j == len - 1);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin out_ready = 1'($urandom_range(0, 1)); @(posedge ap_clk); #1; end
        out_ready = 1'b1;
      end
    join
    wait_results(exp_d.size());
    n_cmp++;
    if (act_d.size() != exp_d.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", act_d.size(), exp_d.size()); end
    for (int i = 0; i < act_d.size() && i < exp_d.size(); i++) begin
      n_cmp++;
      if (act_d[i] != exp_d[i] || act_o[i] != exp_o[i]) begin
        n_err++;
        $display("FAIL rand_result[%0d]: got %0d/ovf %b want %0d/ovf %b", i, act_d[i], act_o[i], exp_d[i], exp_o[i]);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_window();
    test_back_to_back();
    test_saturate();
    test_stall();
    test_reset_mid();
    test_gappy_valid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
